// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract unit: adds or subtracts two WIDTH-bit operands LSB-first,
// DIGIT bits per clock, through one ripple slice. Results and flags are behind a valid/ready handshake.
module serial_addsub_unit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTEPS = WIDTH / DIGIT;
  localparam int CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NSTEPS - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_addsub_unit: WIDTH must be >= 2 and an exact multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cy_q, cy_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] a_dig, b_dig, s_dig;
  logic             ripple_c;

  // Select the operand digit addressed by the step counter.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int k = 0; k < NSTEPS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_dig = a_q[k*DIGIT +: DIGIT];
        b_dig = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  // One DIGIT-wide slice: full-adder ripple for add, borrow ripple for subtract.
  always_comb begin
    s_dig    = '0;
    ripple_c = cy_q;
    for (int i = 0; i < DIGIT; i++) begin
      s_dig[i] = a_dig[i] ^ b_dig[i] ^ ripple_c;
      if (sub_q) begin
        ripple_c = (~a_dig[i] & b_dig[i]) | (~(a_dig[i] ^ b_dig[i]) & ripple_c);
      end else begin
        ripple_c = (a_dig[i] & b_dig[i]) | ((a_dig[i] ^ b_dig[i]) & ripple_c);
      end
    end
  end

  assign in_ready  = (state_q == IDLE) && !abort && !rst;
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign cout      = cy_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    cy_d    = cy_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          cnt_d   = '0;
          res_d   = '0;
          cy_d    = 1'b0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          for (int k = 0; k < NSTEPS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              res_d[k*DIGIT +: DIGIT] = s_dig;
            end
          end
          cy_d  = ripple_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            // Flags are latched with the final digit so they stay stable through DONE.
            zero_d  = (res_d == '0);
            ovf_d   = sub_q ? ((a_msb_q != b_msb_q) && (res_d[WIDTH-1] != a_msb_q))
                            : ((a_msb_q == b_msb_q) && (res_d[WIDTH-1] != a_msb_q));
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // abort outranks out_ready: an aborted result is never consumed.
        if (abort || out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, because result and flags must read 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit: two instances (DIGIT=1 and DIGIT=8), exercised one at a time,
// with expected results from an arithmetic model and a monitor that compares whenever out_valid is high.
module tb_serial_addsub_unit;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         sel;
  logic         in_valid, abort, out_ready, sub;
  logic [W-1:0] a, b;

  logic         ir1, ov1, co1, of1, z1;
  logic [W-1:0] res1;
  logic         ir8, ov8, co8, of8, z8;
  logic [W-1:0] res8;

  logic         iv1, ab1, or1, iv8, ab8, or8;
  logic         in_ready_m, out_valid_m, cout_m, ovf_m, zero_m;
  logic [W-1:0] result_m;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t scoreboard[$];

  assign iv1 = in_valid & ~sel;
  assign ab1 = abort & ~sel;
  assign or1 = out_ready & ~sel;
  assign iv8 = in_valid & sel;
  assign ab8 = abort & sel;
  assign or8 = out_ready & sel;

  assign in_ready_m  = sel ? ir8 : ir1;
  assign out_valid_m = sel ? ov8 : ov1;
  assign result_m    = sel ? res8 : res1;
  assign cout_m      = sel ? co8 : co1;
  assign ovf_m       = sel ? of8 : of1;
  assign zero_m      = sel ? z8 : z1;

  serial_addsub_unit #(.WIDTH(W), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b), .sub(sub),
    .abort(ab1), .out_valid(ov1), .out_ready(or1), .result(res1), .cout(co1), .ovf(of1), .zero(z1)
  );

  serial_addsub_unit #(.WIDTH(W), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b), .sub(sub),
    .abort(ab8), .out_valid(ov8), .out_ready(or8), .result(res8), .cout(co8), .ovf(of8), .zero(z8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nsteps_cur();
    return sel ? (W / 8) : W;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic, signed overflow judged by range of the true result.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
    exp_t   e;
    longint ua, ub, sa, sbv, full, st;
    logic [63:0] fbits;
    ua  = longint'({32'b0, ma});
    ub  = longint'({32'b0, mb});
    sa  = longint'($signed(ma));
    sbv = longint'($signed(mb));
    if (ms) begin
      full   = ua - ub;
      e.cout = (ua < ub);
      st     = sa - sbv;
    end else begin
      full   = ua + ub;
      fbits  = full;
      e.cout = fbits[32];
      st     = sa + sbv;
    end
    fbits  = full;
    e.res  = fbits[W-1:0];
    e.ovf  = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    e.zero = (e.res == '0);
    e.acc  = 0;
    return e;
  endfunction

  // Monitor: compares presented outputs with the head of the scoreboard, pops on handshake.
  logic prev_ov = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid_m) begin
      if (scoreboard.size() == 0) begin
        check("spurious_out_valid", out_valid_m, 1'b0);
      end else begin
        e = scoreboard[0];
        if (!prev_ov) check("latency", 64'(cyc - e.acc), 64'(nsteps_cur()));
        check("result", result_m, e.res);
        check("cout", cout_m, e.cout);
        check("ovf", ovf_m, e.ovf);
        check("zero", zero_m, e.zero);
        check("in_ready_low_in_done", in_ready_m, 1'b0);
        if (out_ready && !abort) void'(scoreboard.pop_front());
      end
    end
    prev_ov = out_valid_m;
  end

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is, output int acc);
    exp_t e;
    acc = -1;
    @(posedge clk); #1;
    a = ia; b = ib; sub = is; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready_m) begin
        acc = cyc + 1;
        break;
      end
    end
    if (acc < 0) begin
      check("accept_timeout", in_ready_m, 1'b1);
    end else begin
      e = model(ia, ib, is);
      e.acc = acc;
      scoreboard.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid();
    bit got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid_m) begin
        got = 1;
        break;
      end
    end
    if (!got) check("valid_timeout", out_valid_m, 1'b1);
  endtask

  task automatic consume(input int hold);
    wait_valid();
    repeat (hold + 1) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is, input int hold);
    int acc;
    issue(ia, ib, is, acc);
    consume(hold);
  endtask

  task automatic drain();
    bit empty = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (scoreboard.size() == 0) begin
        empty = 1;
        break;
      end
    end
    if (!empty) check("drain_timeout", 64'(scoreboard.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic random_ops(input int n);
    for (int i = 0; i < n; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic backpressure_and_b2b();
    int acc, acc1, acc2;
    issue($urandom, $urandom, 1'b1, acc);
    wait_valid();
    repeat (10) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_out_valid_falls", out_valid_m, 1'b0);
    check("bp_in_ready_returns", in_ready_m, 1'b1);
    issue($urandom, $urandom, 1'b0, acc1);
    issue($urandom, $urandom, 1'b1, acc2);
    check("initiation_interval", 64'(acc2 - acc1), 64'(nsteps_cur() + 2));
    drain();
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    sub = 1'b0; a = '0; b = '0;

    @(negedge clk);
    check("rst_in_ready", in_ready_m, 1'b0);
    check("rst_out_valid", out_valid_m, 1'b0);
    check("rst_result", result_m, '0);
    check("rst_flags", {cout_m, ovf_m, zero_m}, 3'b000);
    check("rst_out_valid_d8", ov8, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready_m, 1'b1);

    // DIGIT=1 instance
    run_op(32'd5, 32'd3, 1'b1, 0);
    run_op(32'd0, 32'd1, 1'b1, 1);
    run_op(32'h8000_0000, 32'd1, 1'b1, 0);
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 2);
    random_ops(8);

    // abort while BUSY at step 10
    issue(32'h1234_5678, 32'h0000_0FFF, 1'b1, acc);
    repeat (10) @(posedge clk);
    #1 abort = 1'b1;
    void'(scoreboard.pop_front());
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    check("abort_in_ready", in_ready_m, 1'b1);
    check("abort_no_out_valid", out_valid_m, 1'b0);
    repeat (40) @(negedge clk);
    check("abort_still_idle", in_ready_m, 1'b1);

    // abort with in_valid in IDLE blocks acceptance
    @(posedge clk); #1 abort = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("abort_blocks_in_ready", in_ready_m, 1'b0);
    @(posedge clk); #1 abort = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("abort_idle_not_accepted", in_ready_m, 1'b1);

    backpressure_and_b2b();

    // async reset mid-BUSY
    issue(32'hFFFF_FFFF, 32'd0, 1'b0, acc);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    scoreboard.delete();
    #1;
    check("midrst_out_valid", out_valid_m, 1'b0);
    check("midrst_result", result_m, '0);
    check("midrst_flags", {cout_m, ovf_m, zero_m}, 3'b000);
    check("midrst_in_ready", in_ready_m, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    run_op(32'd7, 32'd7, 1'b1, 0);

    // DIGIT=8 instance
    @(posedge clk); #1 sel = 1'b1;
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1);
    run_op(32'd0, 32'd1, 1'b1, 0);
    random_ops(10);
    backpressure_and_b2b();

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(scoreboard.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub_unit.md
# serial_addsub_unit

Parametrised, multi-cycle integer add/subtract unit that processes operands LSB-first, DIGIT bits per clock, through a single DIGIT-wide borrow/carry slice. It generalises the 32-bit ripple subtractor into a width- and digit-configurable datapath with add/sub mode, status flags and valid/ready handshakes. It sits in the ALU path wherever area matters more than latency.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
- Derived: NSTEPS = WIDTH/DIGIT.

Ports:
- clk  input  1  rising-edge clock; only clock in the block.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH  minuend / addend.
- b  input  WIDTH  subtrahend / addend.
- sub  input  1  1 = a − b, 0 = a + b.
- abort  input  1  synchronous cancel of the current operation.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  a ± b modulo 2^WIDTH.
- cout  output  1  add: carry out; sub: borrow out (1 iff a < b unsigned).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

## Operation
- States: IDLE, BUSY, DONE; reset state IDLE.
- IDLE: in_ready = !abort. When in_valid && in_ready at an edge, capture a, b, sub. Also capture a[WIDTH-1] and b[WIDTH-1]. Clear step counter and the result register. Set the carry/borrow register to 0. Go to BUSY.
- BUSY: on each edge process digit k (bits [k*DIGIT +: DIGIT], k = 0..NSTEPS-1):
  - sub: D = a ^ b ^ bin per bit; bout = (~a & b) | (~(a ^ b) & bin), rippled through DIGIT bits.
  - add: standard full-adder ripple.
  - Write the digit into result bits [k*DIGIT +: DIGIT]. Hold the slice's final borrow/carry for the next digit.
  - On the edge processing k = NSTEPS-1, go to DONE.
- DONE: out_valid = 1. cout = final carry/borrow.
  - ovf (sub) = (a_msb != b_msb) && (r_msb != a_msb).
  - ovf (add) = (a_msb == b_msb) && (r_msb != a_msb).
  - zero = (result == 0).
  - On out_valid && out_ready, go to IDLE.
- in_ready is 0 in BUSY and DONE. There is no overlap of the output handshake with a new input.
- abort, sampled at an edge:
  - In BUSY or DONE: go to IDLE and discard the operation. out_valid falls after that edge.
  - In IDLE: blocks acceptance that cycle.
  - abort has priority over out_ready in DONE; the result counts as not consumed.
- Operand inputs are don't-care outside the accepting edge. Captured operands are unaffected by later input changes.

## Timing
- Reset (asynchronous, while rst high):
  - State goes to IDLE.
  - out_valid, result, cout, ovf and zero go to 0.
  - in_ready is forced to 0 while rst is high. It goes to 1 in the first cycle after release, if abort is low.
- Reset mid-BUSY or mid-DONE: the operation is lost and no out_valid is produced.
- Latency: out_valid rises NSTEPS cycles after the accepting edge.
- Minimum initiation interval: NSTEPS + 2 cycles (accept, NSTEPS BUSY cycles, 1 DONE cycle with out_ready high, return to IDLE).
- Outputs in DONE are registered and held stable until the handshake, abort or reset.
- result, cout, ovf and zero are not guaranteed meaningful while out_valid = 0.
- in_ready is combinational from state, abort and rst. It has no combinational path from in_valid.

## Test plan
- WIDTH=32, DIGIT=1, sub: a=5, b=3 → result=2, cout=0, ovf=0, zero=0. out_valid is asserted exactly 32 cycles after the accepting edge.
- sub: a=0, b=1 → result=0xFFFFFFFF, cout=1, ovf=0. Then a=0x80000000, b=1 → result=0x7FFFFFFF, cout=0, ovf=1.
- WIDTH=32, DIGIT=8, add: a=0xFFFFFFFF, b=1 → result=0, cout=1, zero=1, ovf=0, with latency 4. Then a=0x7FFFFFFF, b=1 → result=0x80000000, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Outputs stay stable and in_ready stays 0. Raise out_ready: out_valid falls and in_ready is 1 the next cycle. A back-to-back accept gives an interval of NSTEPS+2.
- abort in BUSY at step 10 (DIGIT=1): no out_valid appears and in_ready is 1 on the next cycle. Then abort=1 together with in_valid=1 in IDLE: no acceptance.
- rst pulsed asynchronously mid-BUSY: all outputs are 0 immediately. A new sub 7−7 after release gives result=0, zero=1, cout=0 with normal latency.
